// File: rtl/pwm_bank.sv
// Bank of independent PWM channels, each with a prescaler and a double-buffered config.
// Optional output polarity control is enabled by defining PWM_BANK_POLARITY_EN.
module pwm_bank #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16,
  parameter int DIV_W  = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [DIV_W-1:0]  cfg_div,
`ifdef PWM_BANK_POLARITY_EN
  input  logic              cfg_pol,
`endif
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] period_done
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(i);

    logic [CNT_W-1:0] pend_high, pend_period, act_high, act_period, cnt;
    logic [DIV_W-1:0] pend_div, act_div, pc;
    logic             done_q;
    logic             sel, running, tick, wrap, raw;
`ifdef PWM_BANK_POLARITY_EN
    logic             pend_pol, act_pol;
`endif

    // Out-of-range channel numbers never match any IDX, so those writes are dropped.
    assign sel     = cfg_we && (cfg_ch == IDX);
    assign running = (act_div != '0);
    assign tick    = running && (pc == act_div - DIV_W'(1));
    assign wrap    = tick && (cnt == act_period);

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        pend_high   <= '0;
        pend_period <= '0;
        pend_div    <= '0;
        act_high    <= '0;
        act_period  <= '0;
        act_div     <= '0;
        pc          <= '0;
        cnt         <= '0;
        done_q      <= 1'b0;
      end else begin
        if (sel) begin
          pend_high   <= cfg_high;
          pend_period <= cfg_period;
          pend_div    <= cfg_div;
        end
        if (!running) begin
          act_high   <= pend_high;
          act_period <= pend_period;
          act_div    <= pend_div;
          pc         <= '0;
          cnt        <= '0;
          done_q     <= 1'b0;
        end else begin
          done_q <= wrap;
          if (tick) begin
            pc <= '0;
            if (wrap) begin
              cnt <= '0;
              // A write landing on the wrap edge bypasses pending so it is not lost.
              act_high   <= sel ? cfg_high   : pend_high;
              act_period <= sel ? cfg_period : pend_period;
              act_div    <= sel ? cfg_div    : pend_div;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            pc <= pc + DIV_W'(1);
          end
        end
      end
    end

`ifdef PWM_BANK_POLARITY_EN
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        pend_pol <= 1'b0;
        act_pol  <= 1'b0;
      end else begin
        if (sel) pend_pol <= cfg_pol;
        if (!running) act_pol <= pend_pol;
        else if (wrap) act_pol <= sel ? cfg_pol : pend_pol;
      end
    end
`endif

    assign raw = running && (cnt < act_high);

`ifdef PWM_BANK_POLARITY_EN
    assign pwm_out[i] = act_pol ? ~raw : raw;
`else
    assign pwm_out[i] = raw;
`endif
    assign period_done[i] = done_q;
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: directed vector table, corner-case sequences and
// randomized writes checked against a cycle-phase reference model.
module tb_pwm_bank;
  localparam int NCH = 3;
  localparam int CNT_W = 16;
  localparam int DIV_W = 8;
  localparam int CH_W = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_we = 1'b0;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [CNT_W-1:0] cfg_high = '0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic [DIV_W-1:0] cfg_div = '0;
`ifdef PWM_BANK_POLARITY_EN
  logic             cfg_pol = 1'b0;
`endif
  logic [NCH-1:0]   pwm_out;
  logic [NCH-1:0]   period_done;

  pwm_bank #(.NUM_CH(NCH), .CNT_W(CNT_W), .DIV_W(DIV_W), .CH_W(CH_W)) dut (
    .clock(clock),
    .reset(reset),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_high(cfg_high),
    .cfg_period(cfg_period),
    .cfg_div(cfg_div),
`ifdef PWM_BANK_POLARITY_EN
    .cfg_pol(cfg_pol),
`endif
    .pwm_out(pwm_out),
    .period_done(period_done)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  // Reference model: a per-channel phase in clock cycles within the current period.
  int p_high[NCH], p_per[NCH], p_div[NCH], p_pol[NCH];
  int a_high[NCH], a_per[NCH], a_div[NCH], a_pol[NCH];
  int ph[NCH];
  bit m_done[NCH];

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      p_high[i] = 0; p_per[i] = 0; p_div[i] = 0; p_pol[i] = 0;
      a_high[i] = 0; a_per[i] = 0; a_div[i] = 0; a_pol[i] = 0;
      ph[i] = 0; m_done[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    int pol_in;
    pol_in = 0;
`ifdef PWM_BANK_POLARITY_EN
    pol_in = int'(cfg_pol);
`endif
    for (int i = 0; i < NCH; i++) begin
      bit wr;
      wr = cfg_we && (int'(cfg_ch) == i);
      if (a_div[i] == 0) begin
        a_high[i] = p_high[i]; a_per[i] = p_per[i]; a_div[i] = p_div[i]; a_pol[i] = p_pol[i];
        ph[i] = 0;
        m_done[i] = 1'b0;
      end else begin
        m_done[i] = (ph[i] == (a_per[i] + 1) * a_div[i] - 1);
        if (m_done[i]) begin
          ph[i] = 0;
          if (wr) begin
            a_high[i] = int'(cfg_high); a_per[i] = int'(cfg_period);
            a_div[i] = int'(cfg_div); a_pol[i] = pol_in;
          end else begin
            a_high[i] = p_high[i]; a_per[i] = p_per[i]; a_div[i] = p_div[i]; a_pol[i] = p_pol[i];
          end
        end else begin
          ph[i] = ph[i] + 1;
        end
      end
      if (wr) begin
        p_high[i] = int'(cfg_high); p_per[i] = int'(cfg_period);
        p_div[i] = int'(cfg_div); p_pol[i] = pol_in;
      end
    end
  endtask

  function automatic int exp_pwm();
    int v;
    v = 0;
    for (int i = 0; i < NCH; i++) begin
      bit o;
      o = (a_div[i] != 0) && ((ph[i] / a_div[i]) < a_high[i]);
`ifdef PWM_BANK_POLARITY_EN
      if (a_pol[i] != 0) o = (a_div[i] == 0) ? 1'b1 : ~o;
`endif
      if (o) v = v | (1 << i);
    end
    return v;
  endfunction

  function automatic int exp_done();
    int v;
    v = 0;
    for (int i = 0; i < NCH; i++) if (m_done[i]) v = v | (1 << i);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input bit we, input int ch, input int h, input int p, input int d,
                       input bit pol = 1'b0);
    cfg_we = we;
    cfg_ch = CH_W'(ch);
    cfg_high = CNT_W'(h);
    cfg_period = CNT_W'(p);
    cfg_div = DIV_W'(d);
`ifdef PWM_BANK_POLARITY_EN
    cfg_pol = pol;
`else
    if (pol) cfg_we = we;
`endif
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0, 0);
  endtask

  task automatic tick_clk();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    bit   we;
    int   ch;
    int   h;
    int   p;
    int   d;
    logic [NCH-1:0] pwm;
    logic [NCH-1:0] done;
  } vec_t;

  vec_t tbl[22];

  initial begin
    int hi0, hi1, dn, first, second, found;

    tbl[0]  = '{1'b1, 0, 2, 3, 1, 3'b000, 3'b000};
    tbl[1]  = '{1'b0, 0, 0, 0, 0, 3'b001, 3'b000};
    tbl[2]  = '{1'b0, 0, 0, 0, 0, 3'b001, 3'b000};
    tbl[3]  = '{1'b0, 0, 0, 0, 0, 3'b000, 3'b000};
    tbl[4]  = '{1'b0, 0, 0, 0, 0, 3'b000, 3'b000};
    tbl[5]  = '{1'b0, 0, 0, 0, 0, 3'b001, 3'b001};
    tbl[6]  = '{1'b0, 0, 0, 0, 0, 3'b001, 3'b000};
    tbl[7]  = '{1'b0, 0, 0, 0, 0, 3'b000, 3'b000};
    tbl[8]  = '{1'b0, 0, 0, 0, 0, 3'b000, 3'b000};
    tbl[9]  = '{1'b0, 0, 0, 0, 0, 3'b001, 3'b001};
    tbl[10] = '{1'b1, 0, 1, 3, 1, 3'b001, 3'b000};
    tbl[11] = '{1'b1, 3, 0, 0, 1, 3'b000, 3'b000};
    tbl[12] = '{1'b0, 0, 0, 0, 0, 3'b000, 3'b000};
    tbl[13] = '{1'b0, 0, 0, 0, 0, 3'b001, 3'b001};
    tbl[14] = '{1'b0, 0, 0, 0, 0, 3'b000, 3'b000};
    tbl[15] = '{1'b0, 0, 0, 0, 0, 3'b000, 3'b000};
    tbl[16] = '{1'b0, 0, 0, 0, 0, 3'b000, 3'b000};
    tbl[17] = '{1'b1, 0, 3, 3, 1, 3'b001, 3'b001};
    tbl[18] = '{1'b0, 0, 0, 0, 0, 3'b001, 3'b000};
    tbl[19] = '{1'b0, 0, 0, 0, 0, 3'b001, 3'b000};
    tbl[20] = '{1'b0, 0, 0, 0, 0, 3'b000, 3'b000};
    tbl[21] = '{1'b0, 0, 0, 0, 0, 3'b001, 3'b001};

    // Reset state
    model_reset();
    #2;
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_done", int'(period_done), 0);
    @(negedge clock);
    reset = 1'b0;

    // Directed table: basic waveform, mid-period write, invalid channel, wrap-coincident write
    for (int k = 0; k < 22; k++) begin
      drive(tbl[k].we, tbl[k].ch, tbl[k].h, tbl[k].p, tbl[k].d);
      tick_clk();
      check($sformatf("tbl%0d_pwm", k), int'(pwm_out), int'(tbl[k].pwm));
      check($sformatf("tbl%0d_done", k), int'(period_done), int'(tbl[k].done));
    end

    // ch1 with prescaler 3: 12-cycle period, 6 high; ch0 keeps its 3-of-4 pattern
    drive(1'b1, 1, 2, 3, 3);
    tick_clk();
    idle();
    tick_clk();
    tick_clk();
    hi0 = 0; hi1 = 0; first = -1; second = -1;
    for (int k = 0; k < 36; k++) begin
      tick_clk();
      if (k < 12) begin
        hi0 += int'(pwm_out[0]);
        hi1 += int'(pwm_out[1]);
      end
      if (period_done[1]) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    check("ch1_high_cycles", hi1, 6);
    check("ch0_high_cycles", hi0, 9);
    check("ch1_period_cycles", second - first, 12);

    // Boundaries on ch2: high=0, high>period, div=0
    drive(1'b1, 2, 0, 3, 1);
    tick_clk();
    idle();
    tick_clk();
    tick_clk();
    hi0 = 0; dn = 0;
    for (int k = 0; k < 8; k++) begin
      tick_clk();
      hi0 += int'(pwm_out[2]);
      dn += int'(period_done[2]);
    end
    check("high0_pwm", hi0, 0);
    check("high0_done", dn, 2);

    drive(1'b1, 2, 5, 3, 1);
    tick_clk();
    idle();
    for (int k = 0; k < 4; k++) tick_clk();
    hi0 = 0;
    for (int k = 0; k < 8; k++) begin
      tick_clk();
      hi0 += int'(pwm_out[2]);
    end
    check("high_gt_period_pwm", hi0, 8);

    drive(1'b1, 2, 5, 3, 0);
    tick_clk();
    idle();
    for (int k = 0; k < 6; k++) tick_clk();
    hi0 = 0; dn = 0;
    for (int k = 0; k < 8; k++) begin
      tick_clk();
      hi0 += int'(pwm_out[2]);
      dn += int'(period_done[2]);
    end
    check("div0_pwm", hi0, 0);
    check("div0_done", dn, 0);

    // Asynchronous reset while ch0 is high
    found = 0;
    for (int k = 0; k < 8 && found == 0; k++) begin
      if (pwm_out[0]) found = 1;
      else tick_clk();
    end
    check("pre_reset_high", found, 1);
    #1 reset = 1'b1;
    #1 check("async_reset_drop", int'(pwm_out), 0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    hi0 = 0; dn = 0;
    for (int k = 0; k < 8; k++) begin
      tick_clk();
      hi0 += int'(pwm_out != '0);
      dn += int'(period_done != '0);
    end
    check("post_reset_idle_pwm", hi0, 0);
    check("post_reset_idle_done", dn, 0);
    drive(1'b1, 0, 2, 3, 1);
    tick_clk();
    idle();
    tick_clk();
    check("resume_after_write", int'(pwm_out[0]), 1);

`ifdef PWM_BANK_POLARITY_EN
    do_reset();
    drive(1'b1, 0, 2, 3, 1, 1'b1);
    tick_clk();
    idle();
    for (int k = 0; k < 8; k++) begin
      tick_clk();
      check($sformatf("pol_seq%0d", k), int'(pwm_out[0]), ((k % 4) >= 2) ? 1 : 0);
    end
    drive(1'b1, 0, 2, 3, 0, 1'b1);
    tick_clk();
    idle();
    for (int k = 0; k < 6; k++) tick_clk();
    hi0 = 0;
    for (int k = 0; k < 4; k++) begin
      tick_clk();
      hi0 += int'(pwm_out[0]);
    end
    check("pol_disabled_high", hi0, 4);
`endif

    // Randomized writes against the reference model
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 3) == 0)
        drive(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
      else
        idle();
      tick_clk();
      check("rand_pwm", int'(pwm_out), exp_pwm());
      check("rand_done", int'(period_done), exp_done());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
